// File: rtl/queue_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : queue_wr_arbiter_pkg
//  Description : Shared constants for the queue write arbiter: FSM state
//                encoding, default sizing and requester source ids.
//  Revision    : 1.0  initial release
// ============================================================================
package queue_wr_arbiter_pkg;

    // Default sizing; DEPTH must match the Queue instantiated in the parent
    localparam int unsigned c_DATA_W_DEF = 32;
    localparam int unsigned c_DEPTH_DEF  = 8;
    localparam int unsigned c_CNT_W_DEF  = 4;

    // Controller FSM encoding
    typedef logic [0:0] state_t;
    localparam state_t c_ST_RUN   = 1'b0;
    localparam state_t c_ST_DRAIN = 1'b1;

    // Source id carried in the MSB of each queue entry
    localparam logic c_SRC_REQ0 = 1'b0;
    localparam logic c_SRC_REQ1 = 1'b1;

endpackage : queue_wr_arbiter_pkg
`default_nettype wire

// File: rtl/queue_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : queue_wr_arbiter_if
//  Description : Bundle of the requester, Queue and downstream handshake
//                signals around the queue write arbiter. The master modport
//                is the arbiter's view; slave is the surrounding environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface queue_wr_arbiter_if #(
    parameter int unsigned DATA_W = 32
) ();

    // Requester side
    logic              req0_valid_i;
    logic [DATA_W-1:0] req0_data_i;
    logic              req0_ready_o;
    logic              req1_valid_i;
    logic [DATA_W-1:0] req1_data_i;
    logic              req1_ready_o;

    // Queue side
    logic              q_we_o;
    logic [DATA_W:0]   q_wdata_o;
    logic              q_used_o;
    logic [DATA_W:0]   q_rdata_i;
    logic              q_rdata_valid_i;

    // Downstream consumer side
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_src_o;
    logic              out_ready_i;

    modport master (
        input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
        input  q_rdata_i, q_rdata_valid_i, out_ready_i,
        output req0_ready_o, req1_ready_o,
        output q_we_o, q_wdata_o, q_used_o,
        output out_valid_o, out_data_o, out_src_o
    );

    modport slave (
        output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
        output q_rdata_i, q_rdata_valid_i, out_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  q_we_o, q_wdata_o, q_used_o,
        input  out_valid_o, out_data_o, out_src_o
    );

endinterface : queue_wr_arbiter_if
`default_nettype wire

// File: rtl/queue_wr_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : queue_wr_arbiter_rr_arb2
//  Description : Two-way round-robin arbiter. Combinational grant from the
//                request vector; one priority flop (0 = requester 0 first).
//  Revision    : 1.0  initial release
// ============================================================================
module queue_wr_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,      // arbitration allowed this cycle
    input  logic       i_clr,     // force priority back to requester 0
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    logic r_rr;

    // Grant: contention resolved by r_rr, a lone requester always wins
    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            if (i_valid == 2'b11) begin
                o_grant = r_rr ? 2'b10 : 2'b01;
            end else begin
                o_grant = i_valid;
            end
        end
    end

    // Priority flips to the other requester after each grant, holds otherwise
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_rr <= 1'b0;
        end else if (o_grant[0]) begin
            r_rr <= 1'b1;
        end else if (o_grant[1]) begin
            r_rr <= 1'b0;
        end
    end

endmodule : queue_wr_arbiter_rr_arb2
`default_nettype wire

// File: rtl/queue_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : queue_wr_arbiter
//  Description : Controller in front of a single-write/single-read Queue.
//                Round-robins two requesters onto the write port, tracks
//                occupancy for backpressure, forwards the head entry to a
//                valid/ready consumer and drains the Queue on flush.
//  Revision    : 1.0  initial release
// ============================================================================
module queue_wr_arbiter
    import queue_wr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = c_DATA_W_DEF,
    parameter int unsigned DEPTH  = c_DEPTH_DEF,
    parameter int unsigned CNT_W  = c_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,     // active-high despite the name
    input  logic                 flush_i,
    queue_wr_arbiter_if.master   bus,
    output logic [CNT_W-1:0]     count_o,
    output logic                 busy_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;

    logic       w_run;
    logic       w_drain;
    logic       w_space;
    logic       w_arb_en;
    logic [1:0] w_grant;
    logic       w_we;
    logic       w_out_valid;
    logic       w_pop;
    logic       w_drain_pop;

    // Every output is forced quiet while reset is held
    assign w_run       = (r_state == c_ST_RUN)   && !rst_n;
    assign w_drain     = (r_state == c_ST_DRAIN) && !rst_n;
    // No pop bypass: a full queue refuses writes even when popping
    assign w_space     = (r_count != CNT_W'(DEPTH));
    assign w_arb_en    = w_run && !flush_i && w_space;
    assign w_we        = |w_grant;
    assign w_out_valid = w_run && !flush_i && bus.q_rdata_valid_i;
    assign w_pop       = w_out_valid && bus.out_ready_i;
    assign w_drain_pop = w_drain && (r_count != '0);

    queue_wr_arbiter_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst_n),
        .i_en    (w_arb_en),
        .i_clr   (w_run && flush_i),
        .i_valid ({bus.req1_valid_i, bus.req0_valid_i}),
        .o_grant (w_grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: flush with entries present drains; drain ends on its last pop
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (flush_i && (r_count != '0)) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (r_count <= CNT_W'(1)) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: w_state_nxt = c_ST_RUN;
        endcase
    end

    // Outputs: write port, pop strobe, downstream view and busy flag
    always_comb begin
        bus.req0_ready_o = w_grant[0];
        bus.req1_ready_o = w_grant[1];
        bus.q_we_o       = w_we;
        bus.q_wdata_o    = '0;
        if (w_grant[1]) begin
            bus.q_wdata_o = {c_SRC_REQ1, bus.req1_data_i};
        end else if (w_grant[0]) begin
            bus.q_wdata_o = {c_SRC_REQ0, bus.req0_data_i};
        end
        bus.q_used_o     = w_pop || w_drain_pop;
        bus.out_valid_o  = w_out_valid;
        bus.out_data_o   = bus.q_rdata_i[DATA_W-1:0];
        bus.out_src_o    = bus.q_rdata_i[DATA_W];
        busy_o           = w_drain;
    end

    // Occupancy mirrors the Queue pointers: +write -pop in RUN, -1 per drain cycle
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_count <= '0;
        end else if (r_state == c_ST_DRAIN) begin
            if (r_count != '0) begin
                r_count <= r_count - CNT_W'(1);
            end
        end else begin
            r_count <= r_count + CNT_W'(w_we) - CNT_W'(w_pop);
        end
    end

    assign count_o = r_count;

endmodule : queue_wr_arbiter
`default_nettype wire

// File: tb/tb_queue_wr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_queue_wr_arbiter
//  Description : Directed bench for queue_wr_arbiter with a behavioural
//                8-entry Queue and a write/read scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_queue_wr_arbiter;

    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [3:0] count;
    logic       busy;

    queue_wr_arbiter_if #(.DATA_W(DW)) bus ();

    queue_wr_arbiter #(.DATA_W(DW), .DEPTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .bus     (bus.master),
        .count_o (count),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DW:0] exp_wr[$];
    logic [DW:0] exp_rd[$];
    logic [DW:0] qm[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural Queue: head visible the cycle after it is written
    always @(posedge clk) begin
        if (rst_n) begin
            qm.delete();
        end else begin
            if (bus.q_used_o && qm.size() != 0) void'(qm.pop_front());
            if (bus.q_we_o) qm.push_back(bus.q_wdata_o);
        end
        bus.q_rdata_valid_i <= (qm.size() != 0);
        bus.q_rdata_i       <= (qm.size() != 0) ? qm[0] : '0;
    end

    // Scoreboard monitor: every write and every downstream pop is checked
    always @(negedge clk) begin
        if (bus.q_we_o === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_write: got %0h expected none", bus.q_wdata_o);
            end else begin
                chk("write", 64'(bus.q_wdata_o), 64'(exp_wr.pop_front()));
            end
        end
        if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
            if (exp_rd.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_read: got %0h expected none", {bus.out_src_o, bus.out_data_o});
            end else begin
                chk("read", 64'({bus.out_src_o, bus.out_data_o}), 64'(exp_rd.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1, input logic ordy);
        flush            = f;
        bus.req0_valid_i = v0;
        bus.req0_data_i  = d0;
        bus.req1_valid_i = v1;
        bus.req1_data_i  = d1;
        bus.out_ready_i  = ordy;
    endtask

    initial begin
        // Reset held with both requesters valid: everything stays quiet
        rst_n = 1'b1;
        drive(0, 1, 32'hA0, 1, 32'hB0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy0", 64'(bus.req0_ready_o), 0);
        chk("rst_rdy1", 64'(bus.req1_ready_o), 0);
        chk("rst_we", 64'(bus.q_we_o), 0);
        chk("rst_used", 64'(bus.q_used_o), 0);
        chk("rst_oval", 64'(bus.out_valid_o), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_count", 64'(count), 0);

        // Both valid every cycle: grants alternate 0,1,0,1
        exp_wr.push_back({1'b0, 32'hA0}); exp_rd.push_back({1'b0, 32'hA0});
        exp_wr.push_back({1'b1, 32'hB0}); exp_rd.push_back({1'b1, 32'hB0});
        exp_wr.push_back({1'b0, 32'hA1}); exp_rd.push_back({1'b0, 32'hA1});
        exp_wr.push_back({1'b1, 32'hB1}); exp_rd.push_back({1'b1, 32'hB1});
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) rst_n = 1'b0;
            drive(0, 1, 32'hA0 + 32'((i + 1) / 2), 1, 32'hB0 + 32'(i / 2), 1);
            @(negedge clk);
            chk("alt_rdy0", 64'(bus.req0_ready_o), 64'(i % 2 == 0));
            chk("alt_rdy1", 64'(bus.req1_ready_o), 64'(i % 2 == 1));
            chk("alt_count", 64'(count), (i == 0) ? 0 : 1);
        end
        tick(); drive(0, 0, 0, 0, 0, 1); @(negedge clk);
        chk("alt_tail_count", 64'(count), 1);
        chk("alt_tail_oval", 64'(bus.out_valid_o), 1);
        tick(); @(negedge clk);
        chk("alt_empty_count", 64'(count), 0);
        chk("alt_empty_oval", 64'(bus.out_valid_o), 0);

        // Only req1, no consumer: fill to 8, then backpressure
        for (int k = 0; k < 8; k++) exp_wr.push_back({1'b1, 32'hC0 + 32'(k)});
        for (int k = 0; k < 5; k++) exp_rd.push_back({1'b1, 32'hC0 + 32'(k)});
        for (int k = 0; k < 8; k++) begin
            tick(); drive(0, 0, 0, 1, 32'hC0 + 32'(k), 0); @(negedge clk);
            chk("fill_rdy1", 64'(bus.req1_ready_o), 1);
            chk("fill_count", 64'(count), 64'(k));
        end
        tick(); drive(0, 0, 0, 1, 32'hC8, 0); @(negedge clk);
        chk("full_rdy1", 64'(bus.req1_ready_o), 0);
        chk("full_we", 64'(bus.q_we_o), 0);
        chk("full_count", 64'(count), 8);
        // Full with a pop: still no write this cycle
        tick(); drive(0, 0, 0, 1, 32'hC8, 1); @(negedge clk);
        chk("fullpop_rdy1", 64'(bus.req1_ready_o), 0);
        chk("fullpop_count", 64'(count), 8);
        exp_wr.push_back({1'b1, 32'hC8});
        tick(); drive(0, 0, 0, 1, 32'hC8, 0); @(negedge clk);
        chk("refill_count", 64'(count), 7);
        chk("refill_rdy1", 64'(bus.req1_ready_o), 1);
        // Full, pop and req0 valid together
        tick(); drive(0, 1, 32'hD0, 0, 0, 1); @(negedge clk);
        chk("nobypass_rdy0", 64'(bus.req0_ready_o), 0);
        chk("nobypass_used", 64'(bus.q_used_o), 1);
        chk("nobypass_count", 64'(count), 8);
        exp_wr.push_back({1'b0, 32'hD0});
        tick(); drive(0, 1, 32'hD0, 0, 0, 0); @(negedge clk);
        chk("req0_after_count", 64'(count), 7);
        chk("req0_after_rdy0", 64'(bus.req0_ready_o), 1);
        // Pop down to 5
        for (int k = 0; k < 3; k++) begin
            tick(); drive(0, 0, 0, 0, 0, 1); @(negedge clk);
            chk("pop_count", 64'(count), 64'(8 - k));
        end

        // Flush at count 5 with both requesters valid
        tick(); drive(1, 1, 32'hE0, 1, 32'hF0, 1); @(negedge clk);
        chk("flush_count", 64'(count), 5);
        chk("flush_rdy0", 64'(bus.req0_ready_o), 0);
        chk("flush_rdy1", 64'(bus.req1_ready_o), 0);
        chk("flush_we", 64'(bus.q_we_o), 0);
        chk("flush_used", 64'(bus.q_used_o), 0);
        chk("flush_oval", 64'(bus.out_valid_o), 0);
        chk("flush_busy", 64'(busy), 0);
        for (int j = 0; j < 5; j++) begin
            tick(); drive(0, 1, 32'hE0, 1, 32'hF0, 1); @(negedge clk);
            chk("drain_busy", 64'(busy), 1);
            chk("drain_used", 64'(bus.q_used_o), 1);
            chk("drain_count", 64'(count), 64'(5 - j));
            chk("drain_rdy0", 64'(bus.req0_ready_o), 0);
            chk("drain_oval", 64'(bus.out_valid_o), 0);
        end
        exp_wr.push_back({1'b0, 32'hE0}); exp_rd.push_back({1'b0, 32'hE0});
        tick(); drive(0, 1, 32'hE0, 1, 32'hF0, 1); @(negedge clk);
        chk("postdrain_busy", 64'(busy), 0);
        chk("postdrain_count", 64'(count), 0);
        chk("postdrain_rdy0", 64'(bus.req0_ready_o), 1);
        chk("postdrain_rdy1", 64'(bus.req1_ready_o), 0);
        tick(); drive(0, 0, 0, 0, 0, 1); @(negedge clk);
        chk("postdrain_pop_count", 64'(count), 1);
        tick(); @(negedge clk);
        chk("postdrain_empty", 64'(count), 0);

        // Flush while empty: only that cycle is suppressed, no DRAIN
        tick(); drive(1, 1, 32'hE1, 1, 32'hF0, 0); @(negedge clk);
        chk("eflush_rdy0", 64'(bus.req0_ready_o), 0);
        chk("eflush_rdy1", 64'(bus.req1_ready_o), 0);
        chk("eflush_busy", 64'(busy), 0);
        exp_wr.push_back({1'b0, 32'hE1}); exp_rd.push_back({1'b0, 32'hE1});
        tick(); drive(0, 1, 32'hE1, 1, 32'hF0, 0); @(negedge clk);
        chk("eflush_next_busy", 64'(busy), 0);
        chk("eflush_next_rdy0", 64'(bus.req0_ready_o), 1);
        chk("eflush_next_rdy1", 64'(bus.req1_ready_o), 0);
        tick(); drive(0, 0, 0, 0, 0, 1); @(negedge clk);
        chk("eflush_pop_count", 64'(count), 1);
        tick(); @(negedge clk);
        chk("eflush_empty", 64'(count), 0);

        // Reset in the middle of a drain
        for (int k = 0; k < 3; k++) exp_wr.push_back({1'b1, 32'hC00 + 32'(k)});
        for (int k = 0; k < 3; k++) begin
            tick(); drive(0, 0, 0, 1, 32'hC00 + 32'(k), 0); @(negedge clk);
            chk("g_rdy1", 64'(bus.req1_ready_o), 1);
            chk("g_count", 64'(count), 64'(k));
        end
        tick(); drive(1, 0, 0, 0, 0, 0); @(negedge clk);
        chk("g_flush_count", 64'(count), 3);
        tick(); drive(0, 0, 0, 0, 0, 1); @(negedge clk);
        chk("g_drain_busy", 64'(busy), 1);
        chk("g_drain_count", 64'(count), 3);
        chk("g_drain_used", 64'(bus.q_used_o), 1);
        tick(); rst_n = 1'b1; @(negedge clk);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_used", 64'(bus.q_used_o), 0);
        chk("midrst_count", 64'(count), 2);
        tick(); rst_n = 1'b0; @(negedge clk);
        chk("after_rst_count", 64'(count), 0);
        chk("after_rst_busy", 64'(busy), 0);
        chk("after_rst_used", 64'(bus.q_used_o), 0);
        chk("after_rst_oval", 64'(bus.out_valid_o), 0);
        tick(); @(negedge clk);
        chk("after_rst_idle_busy", 64'(busy), 0);
        chk("after_rst_idle_count", 64'(count), 0);

        // Every expected write and read must have been observed
        chk("wr_left", 64'(exp_wr.size()), 0);
        chk("rd_left", 64'(exp_rd.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_queue_wr_arbiter
`default_nettype wire
